// File: rtl/apresenta_sequencia.sv
// Presents the stored play sequence on the leds, one entry at a time.
// Optional PAUSA_EN macro adds a pausa input that freezes the lit/dark timing.
module apresenta_sequencia #(
  parameter int T_ON   = 1000,
  parameter int T_OFF  = 500,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] dado_memoria,
`ifdef PAUSA_EN
  input  logic              pausa,
`endif
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ativo,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int CW    = $clog2(T_MAX + 1);
  localparam logic [CW-1:0] ON_LAST  = CW'(T_ON - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(T_OFF - 1);

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    CARREGA = 4'h1,
    MOSTRA  = 4'h2,
    APAGA   = 4'h3,
    FINAL   = 4'hF
  } estado_t;

  estado_t           estado, estado_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [ADDR_W-1:0] limite_reg, limite_d;
  logic [ADDR_W-1:0] endereco_d;
  logic [DATA_W-1:0] leds_d;
  logic              parado;

`ifdef PAUSA_EN
  assign parado = pausa;
`else
  assign parado = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= INICIAL;
      cnt        <= '0;
      limite_reg <= '0;
      endereco   <= '0;
      leds       <= '0;
    end else begin
      estado     <= estado_d;
      cnt        <= cnt_d;
      limite_reg <= limite_d;
      endereco   <= endereco_d;
      leds       <= leds_d;
    end
  end

  always_comb begin
    estado_d   = estado;
    cnt_d      = cnt;
    limite_d   = limite_reg;
    endereco_d = endereco;
    leds_d     = leds;
    case (estado)
      INICIAL: begin
        leds_d = '0;
        if (iniciar) begin
          limite_d   = limite;
          endereco_d = '0;
          estado_d   = CARREGA;
        end
      end
      CARREGA: begin
        leds_d   = dado_memoria;
        cnt_d    = '0;
        estado_d = MOSTRA;
      end
      MOSTRA: begin
        if (!parado) begin
          if (cnt == ON_LAST) begin
            leds_d   = '0;
            cnt_d    = '0;
            estado_d = APAGA;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      APAGA: begin
        leds_d = '0;
        if (!parado) begin
          if (cnt == OFF_LAST) begin
            cnt_d = '0;
            // The last address ends the run without incrementing, so endereco never wraps.
            if (endereco == limite_reg) begin
              estado_d = FINAL;
            end else begin
              endereco_d = endereco + 1'b1;
              estado_d   = CARREGA;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      FINAL: begin
        leds_d   = '0;
        estado_d = INICIAL;
      end
      default: estado_d = INICIAL;
    endcase
  end

  assign ativo     = (estado == CARREGA) || (estado == MOSTRA) || (estado == APAGA);
  assign pronto    = (estado == FINAL);
  assign db_estado = estado;

endmodule

// File: tb/tb_apresenta_sequencia.sv
// Scoreboard bench for apresenta_sequencia: expected entries and pronto times are queued
// at each start; a negedge monitor pops and checks them as the DUT lights leds / raises pronto.
module tb_apresenta_sequencia;
  localparam int T_ON  = 3;
  localparam int T_OFF = 2;
  localparam int P     = 1 + T_ON + T_OFF;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] limite = '0;
  logic [3:0] dado_memoria;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ativo;
  logic       pronto;
  logic [3:0] db_estado;
  logic       pausa = 1'b0;

  logic [3:0] mem [16];
  assign dado_memoria = mem[endereco];

  apresenta_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .ADDR_W(4), .DATA_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .limite(limite),
    .dado_memoria(dado_memoria),
`ifdef PAUSA_EN
    .pausa(pausa),
`endif
    .endereco(endereco),
    .leds(leds),
    .ativo(ativo),
    .pronto(pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  typedef struct { int pat; int addr; int len; } ent_t;
  typedef struct { int cyc; int addr; } fin_t;
  ent_t ent_q[$];
  fin_t fin_q[$];

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int expected_done = 0;

  function automatic void chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cycle);
    end
  endfunction

  // Monitor: each dark->lit transition consumes one expected entry; each pronto consumes one end.
  initial begin
    int len;
    int cur;
    int exp_len;
    ent_t e;
    fin_t f;
    len = 0; cur = 0; exp_len = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        len = 0;
      end else begin
        if (leds != 4'd0) begin
          if (len == 0) begin
            if (ent_q.size() == 0) begin
              chk("unexpected_entry", int'(leds), 0);
              exp_len = T_ON;
            end else begin
              e = ent_q.pop_front();
              chk("entry_pattern", int'(leds), e.pat);
              chk("entry_addr", int'(endereco), e.addr);
              exp_len = e.len;
            end
            cur = int'(leds);
          end else begin
            chk("leds_stable", int'(leds), cur);
          end
          chk("ativo_lit", int'(ativo), 1);
          len++;
        end else if (len != 0) begin
          chk("lit_length", len, exp_len);
          len = 0;
        end
        if (pronto) begin
          if (fin_q.size() == 0) begin
            chk("unexpected_pronto", 1, 0);
          end else begin
            f = fin_q.pop_front();
            chk("pronto_cycle", cycle, f.cyc);
            chk("final_addr", int'(endereco), f.addr);
          end
          chk("ativo_final", int'(ativo), 0);
          done_cnt++;
        end
      end
    end
  end

  // Reference: entry i shows mem[i] for T_ON cycles; run ends (L+1)*P cycles after start.
  task automatic push_run(input int L, input int s, input int pz);
    ent_t e;
    fin_t f;
    for (int i = 0; i <= L; i++) begin
      e.pat  = int'(mem[i]);
      e.addr = i;
      e.len  = (i == 0) ? T_ON + pz : T_ON;
      ent_q.push_back(e);
    end
    f.cyc = s + (L + 1) * P + pz;
    f.addr = L;
    fin_q.push_back(f);
    expected_done++;
  endtask

  task automatic start(input int L, output int s);
    @(negedge clock);
    limite  = 4'(L);
    iniciar = 1'b1;
    @(posedge clock);
    #1 s = cycle;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt < expected_done && n < budget) begin
      @(negedge clock);
      n++;
    end
    #1;
    if (done_cnt < expected_done) begin
      chk("pronto_timeout", done_cnt, expected_done);
      expected_done = done_cnt;
    end
  endtask

  task automatic run_single(input int L, input int pz);
    int s;
    start(L, s);
    push_run(L, s, pz);
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
    #1;
    // Memory and limite changes after latching must not alter the shown sequence.
    mem[0] = {mem[0][2:0], mem[0][3]};
    limite = 4'($urandom_range(0, 15));
    if (pz > 0) begin
      pausa = 1'b1;
      repeat (pz) @(negedge clock);
      #1 pausa = 1'b0;
    end
    wait_done((L + 1) * P + pz + 20);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << $urandom_range(0, 3));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_leds"}, int'(leds), 0);
    chk({tag, "_endereco"}, int'(endereco), 0);
    chk({tag, "_pronto"}, int'(pronto), 0);
    chk({tag, "_ativo"}, int'(ativo), 0);
    chk({tag, "_db_estado"}, int'(db_estado), 0);
  endtask

  initial begin
    int s;
    int p2;
    int n;
    randomize_mem();
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
    repeat (3) @(negedge clock);
    check_idle("in_reset");
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_idle("idle");
    end

    run_single(3, 0);
    run_single(0, 0);
    randomize_mem();
    run_single(15, 0);

    // Asynchronous reset in the middle of the second entry.
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
    start(3, s);
    push_run(3, s, 0);
    @(negedge clock);
    iniciar = 1'b0;
    while (cycle < s + 8) @(negedge clock);
    chk("pre_reset_leds", int'(leds), 2);
    #2 reset = 1'b0;
    #1 check_idle("async_reset");
    ent_q.delete();
    fin_q.delete();
    expected_done = done_cnt;
    repeat (2) @(negedge clock);
    check_idle("held_reset");
    #1 reset = 1'b1;
    run_single(2, 0);

    for (int k = 0; k < 4; k++) begin
      randomize_mem();
      run_single($urandom_range(0, 15), 0);
    end

    // iniciar held high: one INICIAL cycle separates pronto from the next CARREGA.
    randomize_mem();
    start(1, s);
    push_run(1, s, 0);
    push_run(1, s + 2 * P + 2, 0);
    p2 = s + 4 * P + 2;
    n = 0;
    while (cycle < p2 && n < 200) begin
      @(negedge clock);
      n++;
    end
    #1 iniciar = 1'b0;
    wait_done(40);

`ifdef PAUSA_EN
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
    run_single(3, 4);
`endif

    repeat (10) @(negedge clock);
    chk("entries_left", ent_q.size(), 0);
    chk("finals_left", fin_q.size(), 0);
    chk("final_idle_ativo", int'(ativo), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
